// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - shared encodings for the execute-stage M-extension unit
package ex_muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] FUNC3_MUL    = 3'b000;
    localparam logic [2:0] FUNC3_MULH   = 3'b001;
    localparam logic [2:0] FUNC3_MULHSU = 3'b010;
    localparam logic [2:0] FUNC3_MULHU  = 3'b011;
    localparam logic [2:0] FUNC3_DIV    = 3'b100;
    localparam logic [2:0] FUNC3_DIVU   = 3'b101;
    localparam logic [2:0] FUNC3_REM    = 3'b110;
    localparam logic [2:0] FUNC3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_SIGN = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv_unit_div_step.sv
// rtl/ex_muldiv_unit_div_step.sv - one combinational restoring shift-subtract step
module muldiv_div_step #(
    parameter int XLEN = ex_muldiv_pkg::XLEN
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] div_in,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff_lo;
    logic            fits;

    assign shifted = {rem_in, quo_in[XLEN-1]};
    assign fits    = shifted >= {1'b0, div_in};
    // When the divisor fits, the true difference is below 2^XLEN, so the low bits are exact.
    assign diff_lo = shifted[XLEN-1:0] - div_in;

    assign rem_out = fits ? diff_lo : shifted[XLEN-1:0];
    assign quo_out = {quo_in[XLEN-2:0], fits};

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - RV32M multiply (2 cycles) / iterative restoring divide (34 cycles)
module ex_muldiv_unit #(
    parameter int XLEN = ex_muldiv_pkg::XLEN
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Flush,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] Operand1,
    input  logic [XLEN-1:0] Operand2,
    input  logic [4:0]      WriteAddress,
    output logic [XLEN-1:0] Result,
    output logic            Result_Valid,
    output logic [4:0]      Out_WriteAddress,
    output logic            STALL,
    output logic            Busy
);

    import ex_muldiv_pkg::*;

    localparam int CNT_W = $clog2(XLEN + 1);

    muldiv_state_t   state, next_state;
    logic [2:0]      func3_q;
    logic [XLEN-1:0] op1_q, op2_q;
    logic [XLEN-1:0] rem_q, quo_q, div_q;
    logic            quo_neg_q, rem_neg_q;
    logic [CNT_W-1:0] counter;

    logic            accept;
    logic            div_signed;
    logic            div_by_zero, div_overflow, special;
    logic [XLEN-1:0] special_result;
    logic [XLEN-1:0] abs1, abs2;
    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN-1:0] quo_fix, rem_fix, div_result;
    logic [XLEN:0]   a_ext, b_ext;
    logic signed [2*XLEN-1:0] a_wide, b_wide, product;
    logic [XLEN-1:0] mul_result;

    assign accept = (state == ST_IDLE) && Start && !Flush;

    // Divide special cases are decided from the live operands so they finish without iterating.
    assign div_signed     = !func3[0];
    assign div_by_zero    = (Operand2 == '0);
    assign div_overflow   = div_signed && (Operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (&Operand2);
    assign special        = func3[2] && (div_by_zero || div_overflow);
    assign special_result = div_by_zero ? (func3[1] ? Operand1 : '1)
                                        : (func3[1] ? '0 : Operand1);

    assign abs1 = (div_signed && Operand1[XLEN-1]) ? ('0 - Operand1) : Operand1;
    assign abs2 = (div_signed && Operand2[XLEN-1]) ? ('0 - Operand2) : Operand2;

    muldiv_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .div_in  (div_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    assign quo_fix    = quo_neg_q ? ('0 - quo_q) : quo_q;
    assign rem_fix    = rem_neg_q ? ('0 - rem_q) : rem_q;
    assign div_result = func3_q[1] ? rem_fix : quo_fix;

    // 33-bit extension selects signed/unsigned per operand; low 64 bits of the product suffice.
    assign a_ext      = {(func3_q != FUNC3_MULHU) && op1_q[XLEN-1], op1_q};
    assign b_ext      = {((func3_q == FUNC3_MUL) || (func3_q == FUNC3_MULH)) && op2_q[XLEN-1], op2_q};
    assign a_wide     = {{(XLEN-1){a_ext[XLEN]}}, a_ext};
    assign b_wide     = {{(XLEN-1){b_ext[XLEN]}}, b_ext};
    assign product    = a_wide * b_wide;
    assign mul_result = (func3_q == FUNC3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!func3[2])    next_state = ST_MUL;
                    else if (special) next_state = ST_DONE;
                    else              next_state = ST_DIV;
                end
            end
            ST_MUL:  next_state = Flush ? ST_IDLE : ST_DONE;
            ST_DIV: begin
                if (Flush)                       next_state = ST_IDLE;
                else if (counter == CNT_W'(1))   next_state = ST_SIGN;
            end
            ST_SIGN: next_state = Flush ? ST_IDLE : ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state            <= ST_IDLE;
            Busy             <= 1'b0;
            Result           <= '0;
            Out_WriteAddress <= '0;
            counter          <= '0;
            func3_q          <= '0;
            op1_q            <= '0;
            op2_q            <= '0;
            rem_q            <= '0;
            quo_q            <= '0;
            div_q            <= '0;
            quo_neg_q        <= 1'b0;
            rem_neg_q        <= 1'b0;
        end else begin
            state <= next_state;
            Busy  <= (next_state == ST_MUL) || (next_state == ST_DIV) || (next_state == ST_SIGN);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        func3_q          <= func3;
                        op1_q            <= Operand1;
                        op2_q            <= Operand2;
                        Out_WriteAddress <= WriteAddress;
                        rem_q            <= '0;
                        quo_q            <= abs1;
                        div_q            <= abs2;
                        quo_neg_q        <= div_signed && (Operand1[XLEN-1] ^ Operand2[XLEN-1]);
                        rem_neg_q        <= div_signed && Operand1[XLEN-1];
                        if (next_state == ST_DIV) counter <= CNT_W'(XLEN);
                        if (special)              Result  <= special_result;
                    end
                end
                ST_MUL: begin
                    if (!Flush) Result <= mul_result;
                end
                ST_DIV: begin
                    rem_q   <= step_rem;
                    quo_q   <= step_quo;
                    counter <= counter - CNT_W'(1);
                end
                ST_SIGN: begin
                    if (!Flush) Result <= div_result;
                end
                default: ;
            endcase
        end
    end

    assign Result_Valid = (state == ST_DONE) && !Flush && !Reset;
    assign STALL        = accept || Busy;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - randomized self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [2:0]  func3 = '0;
    logic [31:0] Operand1 = '0;
    logic [31:0] Operand2 = '0;
    logic [4:0]  WriteAddress = '0;
    logic [31:0] Result;
    logic        Result_Valid;
    logic [4:0]  Out_WriteAddress;
    logic        STALL;
    logic        Busy;

    int n_err = 0;
    int n_chk = 0;
    logic [31:0] last_result = '0;

    always #5 CLK = ~CLK;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .CLK              (CLK),
        .Reset            (Reset),
        .Start            (Start),
        .Flush            (Flush),
        .func3            (func3),
        .Operand1         (Operand1),
        .Operand2         (Operand2),
        .WriteAddress     (WriteAddress),
        .Result           (Result),
        .Result_Valid     (Result_Valid),
        .Out_WriteAddress (Out_WriteAddress),
        .STALL            (STALL),
        .Busy             (Busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(signed'(a) / signed'(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(signed'(a) % signed'(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return 2;
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge CLK);
        Start = 1'b1; func3 = f; Operand1 = a; Operand2 = b; WriteAddress = rd;
        #1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        int cyc;
        bit got;
        bit stall_ok;
        drive_start(f, a, b, rd);
        check({tag, "_stall0"}, 32'(STALL), 32'd1);
        cyc = 0; got = 0; stall_ok = 1;
        while (!got && cyc < 60) begin
            @(negedge CLK);
            Start = 1'b0;
            cyc++;
            #1;
            if (Result_Valid) got = 1;
            else if (STALL !== 1'b1) stall_ok = 0;
        end
        check({tag, "_timeout"}, 32'(got), 32'd1);
        check({tag, "_stall_busy"}, 32'(stall_ok), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(ref_latency(f, a, b)));
        check({tag, "_result"}, Result, ref_result(f, a, b));
        check({tag, "_rd"}, 32'(Out_WriteAddress), 32'(rd));
        check({tag, "_stall_done"}, 32'(STALL), 32'd0);
        last_result = ref_result(f, a, b);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        bit seen;

        repeat (2) @(negedge CLK);
        #1;
        check("rst_result", Result, 32'h0);
        check("rst_valid", 32'(Result_Valid), 32'd0);
        check("rst_rd", 32'(Out_WriteAddress), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        @(negedge CLK);
        Reset = 1'b0;

        run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        run_op("div", 3'd4, 32'hFFFF_FFEC, 32'd3, 5'd4);
        run_op("rem", 3'd6, 32'hFFFF_FFEC, 32'd3, 5'd5);
        run_op("divu0", 3'd5, 32'd100, 32'd0, 5'd6);
        run_op("remu0", 3'd7, 32'd100, 32'd0, 5'd7);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);

        // Flush together with Start in IDLE: op is not taken
        @(negedge CLK);
        Start = 1'b1; Flush = 1'b1; func3 = 3'd0; Operand1 = 32'd3; Operand2 = 32'd3;
        #1;
        check("idle_flush_stall", 32'(STALL), 32'd0);
        @(negedge CLK);
        Start = 1'b0; Flush = 1'b0;
        #1;
        check("idle_flush_busy", 32'(Busy), 32'd0);
        check("idle_flush_valid", 32'(Result_Valid), 32'd0);

        // Flush while in DONE suppresses the pulse
        drive_start(3'd5, 32'd100, 32'd0, 5'd10);
        @(negedge CLK);
        Start = 1'b0; Flush = 1'b1;
        #1;
        check("done_flush_valid", 32'(Result_Valid), 32'd0);
        @(negedge CLK);
        Flush = 1'b0;
        #1;
        check("done_flush_busy", 32'(Busy), 32'd0);

        run_op("pre_flush", 3'd0, 32'd11, 32'd13, 5'd11);

        // Flush on divide step 10
        drive_start(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd12);
        repeat (10) begin
            @(negedge CLK);
            Start = 1'b0;
        end
        Flush = 1'b1;
        @(negedge CLK);
        Flush = 1'b0;
        #1;
        check("flush_stall", 32'(STALL), 32'd0);
        check("flush_busy", 32'(Busy), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge CLK);
            #1;
            if (Result_Valid) seen = 1;
        end
        check("flush_no_valid", 32'(seen), 32'd0);
        check("flush_result_held", Result, last_result);

        // Reset on divide step 10
        drive_start(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd13);
        repeat (10) begin
            @(negedge CLK);
            Start = 1'b0;
        end
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        check("midrst_result", Result, 32'h0);
        check("midrst_valid", 32'(Result_Valid), 32'd0);
        check("midrst_rd", 32'(Out_WriteAddress), 32'd0);
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_stall", 32'(STALL), 32'd0);
        run_op("mul_after_rst", 3'd0, 32'd5, 32'd6, 5'd14);

        // Back-to-back: second op starts the cycle after DONE
        run_op("b2b_mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd15);
        run_op("b2b_divu", 3'd5, 32'hFFFF_FFFF, 32'd16, 5'd16);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), f, a, b, 5'($urandom_range(0, 31)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Execute-stage M-extension unit. It consumes the operands, func3 and destination register that the ID/EX pipeline register delivers.
- It computes MUL/MULH/MULHSU/MULHU in 2 cycles and DIV/DIVU/REM/REMU in 34 cycles, using an iterative restoring divider.
- It raises STALL to freeze the IF/ID and ID/EX registers until the result is ready.
- The result and write address go to the EX/MEM pipeline register.

Parameters:
- XLEN, 32, operand/result width; the divider runs exactly XLEN steps.

Ports:
- CLK  input  1  clock, rising edge
- Reset  input  1  synchronous, active-high
- Start  input  1  ID/EX holds a valid M-extension op; sampled only in IDLE
- Flush  input  1  branch/jump flush; aborts any operation in flight
- func3  input  3  RV32M func3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU)
- Operand1  input  XLEN  rs1 value (already forwarded)
- Operand2  input  XLEN  rs2 value (already forwarded)
- WriteAddress  input  5  rd of the op
- Result  output  XLEN  registered result, held until the next completion
- Result_Valid  output  1  one-cycle pulse, result ready for EX/MEM
- Out_WriteAddress  output  5  rd latched at Start
- STALL  output  1  pipeline freeze request
- Busy  output  1  registered, high in MUL/DIV/SIGN

Behaviour:
- Interface clocking: reset Reset, synchronous, active-high; clock CLK.
- Reset values: state=IDLE; Result=0, Result_Valid=0, Out_WriteAddress=0, Busy=0; counter=0.
  - Reset overrides Start and Flush.
  - Reset mid-operation drops the operation; no Result_Valid is produced.
- States and transitions:
  - IDLE, Start&&!Flush:
    - Latch func3, operands and WriteAddress.
    - func3[2]=0 -> MUL.
    - func3[2]=1 and special case -> DONE.
    - Otherwise -> DIV with counter=XLEN.
  - MUL -> DONE. Form the 64-bit product of 33-bit extended operands:
    - MUL/MULH: both signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - MULHU: both unsigned.
    - Result = low 32 bits for MUL, high 32 bits otherwise.
  - DIV: one restoring shift-subtract step per cycle on magnitudes (signed ops take abs; unsigned ops use raw operands). Counter decrements each cycle; at counter==1 -> SIGN.
  - SIGN -> DONE:
    - Quotient is negated if the operand signs differ (signed DIV only).
    - Remainder takes the dividend's sign (signed REM only).
    - Result = quotient (DIV/DIVU) or remainder (REM/REMU).
  - DONE: Result_Valid=1 for this cycle only -> IDLE. A Start in the following cycle is accepted normally.
- Special cases (resolved in IDLE, no iteration):
  - Divisor==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV -> 0x80000000, REM -> 0.
- STALL = (state==IDLE && Start && !Flush) || Busy.
  - It is combinational so the ID/EX register holds from the first cycle.
  - It is deasserted in DONE so the pipeline advances exactly when Result_Valid pulses.
- Latency from the Start cycle to the Result_Valid cycle: MUL* 2, DIV* 34, special-case divide 1.
- Flush:
  - In MUL/DIV/SIGN: next state IDLE, Result_Valid stays 0, Result unchanged.
  - In IDLE: Start is ignored.
  - In DONE: Result_Valid is suppressed for that cycle.
- Start outside IDLE is ignored; upstream cannot present a new op while STALL=1.
- Result holds its last value between operations; the bench checks Result only when Result_Valid=1.

Decomposition:
- Shared package holds:
  - func3 encodings (FUNC3_MUL … FUNC3_REMU);
  - the state encoding (IDLE, MUL, DIV, SIGN, DONE; 3 bits);
  - XLEN.
- One sub-module, muldiv_div_step: a combinational single restoring step (remainder, quotient, divisor in -> remainder, quotient out). It is instantiated once and iterated by the counter.

Test Plan:
- MUL 7 × 0xFFFFFFFD -> Result_Valid 2 cycles after Start, Result 0xFFFFFFEB. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000.
- DIV 0xFFFFFFEC (-20) / 3 -> Result_Valid 34 cycles after Start, Result 0xFFFFFFFA. REM same operands -> 0xFFFFFFFE. STALL=1 for cycles 0..33 after Start, 0 on the Result_Valid cycle.
- DIVU 100 / 0 -> 0xFFFFFFFF after 1 cycle. REMU 100 / 0 -> 0x00000064. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- Start DIV, assert Flush on step 10 -> IDLE next cycle, STALL=0, no Result_Valid, Result unchanged.
- Start DIV, assert Reset on step 10 -> all outputs 0 next cycle; a new MUL 5×6 started afterwards yields 0x0000001E in 2 cycles.
- Back-to-back: MULHSU 0xFFFFFFFF × 2 then DIVU 0xFFFFFFFF / 16 started on the cycle after DONE -> 0xFFFFFFFF, then 0x0FFFFFFF with the correct Out_WriteAddress for each.
